// File: rtl/q_update_engine.sv
// Q-learning update engine: scans Q(s',*) for max/argmax, then performs the
// Bellman read-modify-write of Q(s,a) with saturation to Q_WIDTH.
module q_update_engine #(
  parameter int STATE_BITS  = 4,
  parameter int ACTION_BITS = 2,
  parameter int Q_WIDTH     = 16,
  parameter int FRAC_BITS   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   upd_valid,
  output logic                   upd_ready,
  input  logic [STATE_BITS-1:0]  upd_state,
  input  logic [ACTION_BITS-1:0] upd_action,
  input  logic [STATE_BITS-1:0]  upd_next_state,
  input  logic [Q_WIDTH-1:0]     upd_reward,
  input  logic                   upd_terminal,
  input  logic [FRAC_BITS:0]     upd_alpha,
  input  logic [FRAC_BITS:0]     upd_gamma,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [Q_WIDTH-1:0]     res_q,
  output logic [Q_WIDTH-1:0]     res_max_q,
  output logic [ACTION_BITS-1:0] res_best_action,
  output logic                   res_sat,
  output logic                   init_done
);
  localparam int IW = STATE_BITS + ACTION_BITS;
  localparam int W  = Q_WIDTH;
  localparam int PW = Q_WIDTH + FRAC_BITS + 4;
  localparam logic signed [PW-1:0] QMAX = {{(PW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [PW-1:0] QMIN = {{(PW-W+1){1'b1}}, {(W-1){1'b0}}};

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_SCAN, S_UPDATE, S_RESP} state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           cnt_q, cnt_d;
  logic [ACTION_BITS-1:0]  scan_q, scan_d;
  logic [STATE_BITS-1:0]   s_q, s_d, ns_q, ns_d;
  logic [ACTION_BITS-1:0]  a_q, a_d;
  logic [W-1:0]            r_q, r_d;
  logic                    term_q, term_d;
  logic [FRAC_BITS:0]      alpha_q, alpha_d, gamma_q, gamma_d;
  logic signed [W-1:0]     maxv_q, maxv_d;
  logic [ACTION_BITS-1:0]  best_q, best_d;
  logic                    res_valid_q, res_valid_d;
  logic [W-1:0]            res_qv_q, res_qv_d, res_maxv_q, res_maxv_d;
  logic [ACTION_BITS-1:0]  res_best_q, res_best_d;
  logic                    res_sat_q, res_sat_d;
  logic                    upd_ready_q, upd_ready_d;
  logic                    init_done_q, init_done_d;

  // Single-port table: one read address (scan or update), one write per cycle.
  logic [W-1:0]        mem_q [1<<IW];
  logic [IW-1:0]       rd_addr, wr_addr;
  logic signed [W-1:0] rd_data;
  logic [W-1:0]        wr_data;
  logic                wr_en;

  logic signed [PW-1:0] qold_x, maxq_x, r_x, alpha_x, gamma_x;
  logic signed [PW-1:0] gprod, g, td, dprod, d, qsum;
  logic [W-1:0]         qnew;
  logic                 qsat;

  always_comb begin
    rd_addr = (state_q == S_SCAN) ? {ns_q, scan_q} : {s_q, a_q};
    rd_data = mem_q[rd_addr];
  end

  always_comb begin
    qold_x  = {{(PW-W){rd_data[W-1]}}, rd_data};
    maxq_x  = {{(PW-W){maxv_q[W-1]}}, maxv_q};
    r_x     = {{(PW-W){r_q[W-1]}}, r_q};
    alpha_x = {{(PW-FRAC_BITS-1){1'b0}}, alpha_q};
    gamma_x = {{(PW-FRAC_BITS-1){1'b0}}, gamma_q};
    gprod   = gamma_x * maxq_x;
    g       = gprod >>> FRAC_BITS;
    td      = r_x + g - qold_x;
    dprod   = alpha_x * td;
    d       = dprod >>> FRAC_BITS;
    qsum    = qold_x + d;
    qsat    = 1'b0;
    qnew    = qsum[W-1:0];
    if (qsum > QMAX) begin
      qnew = QMAX[W-1:0];
      qsat = 1'b1;
    end else if (qsum < QMIN) begin
      qnew = QMIN[W-1:0];
      qsat = 1'b1;
    end
  end

  always_comb begin
    wr_en   = (state_q == S_INIT) || (state_q == S_UPDATE);
    wr_addr = (state_q == S_INIT) ? cnt_q : {s_q, a_q};
    wr_data = (state_q == S_INIT) ? '0 : qnew;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    scan_d      = scan_q;
    s_d         = s_q;
    a_d         = a_q;
    ns_d        = ns_q;
    r_d         = r_q;
    term_d      = term_q;
    alpha_d     = alpha_q;
    gamma_d     = gamma_q;
    maxv_d      = maxv_q;
    best_d      = best_q;
    res_valid_d = res_valid_q;
    res_qv_d    = res_qv_q;
    res_maxv_d  = res_maxv_q;
    res_best_d  = res_best_q;
    res_sat_d   = res_sat_q;
    upd_ready_d = upd_ready_q;
    init_done_d = init_done_q;
    case (state_q)
      S_INIT: begin
        cnt_d = cnt_q + IW'(1);
        if (cnt_q == '1) begin
          state_d     = S_IDLE;
          init_done_d = 1'b1;
          upd_ready_d = 1'b1;
        end
      end
      S_IDLE: begin
        if (upd_valid) begin
          s_d         = upd_state;
          a_d         = upd_action;
          ns_d        = upd_next_state;
          r_d         = upd_reward;
          term_d      = upd_terminal;
          alpha_d     = upd_alpha;
          gamma_d     = upd_gamma;
          scan_d      = '0;
          maxv_d      = '0;
          best_d      = '0;
          upd_ready_d = 1'b0;
          state_d     = S_SCAN;
        end
      end
      S_SCAN: begin
        // Strict > keeps the lowest index on ties; terminal pins max/argmax at 0.
        if (!term_q && (scan_q == '0 || rd_data > maxv_q)) begin
          maxv_d = rd_data;
          best_d = scan_q;
        end
        scan_d = scan_q + ACTION_BITS'(1);
        if (scan_q == '1) state_d = S_UPDATE;
      end
      S_UPDATE: begin
        res_qv_d    = qnew;
        res_maxv_d  = maxv_q;
        res_best_d  = best_q;
        res_sat_d   = qsat;
        res_valid_d = 1'b1;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          upd_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_INIT;
      cnt_q       <= '0;
      scan_q      <= '0;
      s_q         <= '0;
      a_q         <= '0;
      ns_q        <= '0;
      r_q         <= '0;
      term_q      <= 1'b0;
      alpha_q     <= '0;
      gamma_q     <= '0;
      maxv_q      <= '0;
      best_q      <= '0;
      res_valid_q <= 1'b0;
      res_qv_q    <= '0;
      res_maxv_q  <= '0;
      res_best_q  <= '0;
      res_sat_q   <= 1'b0;
      upd_ready_q <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      scan_q      <= scan_d;
      s_q         <= s_d;
      a_q         <= a_d;
      ns_q        <= ns_d;
      r_q         <= r_d;
      term_q      <= term_d;
      alpha_q     <= alpha_d;
      gamma_q     <= gamma_d;
      maxv_q      <= maxv_d;
      best_q      <= best_d;
      res_valid_q <= res_valid_d;
      res_qv_q    <= res_qv_d;
      res_maxv_q  <= res_maxv_d;
      res_best_q  <= res_best_d;
      res_sat_q   <= res_sat_d;
      upd_ready_q <= upd_ready_d;
      init_done_q <= init_done_d;
    end
  end

  assign upd_ready       = upd_ready_q;
  assign res_valid       = res_valid_q;
  assign res_q           = res_qv_q;
  assign res_max_q       = res_maxv_q;
  assign res_best_action = res_best_q;
  assign res_sat         = res_sat_q;
  assign init_done       = init_done_q;
endmodule

// File: tb/tb_q_update_engine.sv
// Directed bench for q_update_engine with hand-computed expected values.
module tb_q_update_engine;
  logic        clk = 0;
  logic        rst;
  logic        upd_valid, upd_ready, upd_terminal;
  logic [3:0]  upd_state, upd_next_state;
  logic [1:0]  upd_action;
  logic [15:0] upd_reward;
  logic [8:0]  upd_alpha, upd_gamma;
  logic        res_valid, res_ready, res_sat, init_done;
  logic [15:0] res_q, res_max_q;
  logic [1:0]  res_best_action;

  int checks = 0, failures = 0;

  q_update_engine dut (
    .clk(clk), .rst(rst),
    .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_state(upd_state), .upd_action(upd_action),
    .upd_next_state(upd_next_state), .upd_reward(upd_reward),
    .upd_terminal(upd_terminal), .upd_alpha(upd_alpha), .upd_gamma(upd_gamma),
    .res_valid(res_valid), .res_ready(res_ready), .res_q(res_q),
    .res_max_q(res_max_q), .res_best_action(res_best_action),
    .res_sat(res_sat), .init_done(init_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_init(input string tag);
    int n = 0;
    logic rdy_seen = 0;
    while (n < 200) begin
      @(posedge clk); n++; #1;
      if (init_done) break;
      if (upd_ready) rdy_seen = 1;
    end
    chk({tag, "_init_cycles"}, n, 64);
    chk({tag, "_rdy_during_init"}, rdy_seen, 0);
  endtask

  // Issue one request; returns outputs at res_valid and the edge latency.
  task automatic do_upd(input logic [3:0] s, input logic [1:0] a, input logic [3:0] ns,
                        input logic [15:0] r, input logic term, input logic [8:0] al,
                        input logic [8:0] ga, input int hold,
                        output logic [15:0] q, output logic [15:0] mq,
                        output logic [1:0] best, output logic sat, output int lat);
    int n = 0;
    @(negedge clk);
    while (!upd_ready && n < 50) begin @(negedge clk); n++; end
    upd_state = s; upd_action = a; upd_next_state = ns; upd_reward = r;
    upd_terminal = term; upd_alpha = al; upd_gamma = ga; upd_valid = 1;
    @(posedge clk); #1 upd_valid = 0;
    lat = 0;
    while (lat < 20) begin
      @(posedge clk); lat++; #1;
      if (res_valid) break;
    end
    q = res_q; mq = res_max_q; best = res_best_action; sat = res_sat;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", res_valid, 1);
      chk("hold_q", res_q, q);
      chk("hold_maxq", res_max_q, mq);
      chk("hold_rdy", upd_ready, 0);
    end
    @(negedge clk); res_ready = 1;
    @(posedge clk); #1 res_ready = 0;
    chk("valid_drop", res_valid, 0);
  endtask

  logic [15:0] q, mq;
  logic [1:0]  best;
  logic        sat;
  int          lat;

  initial begin
    rst = 1; upd_valid = 0; res_ready = 0; upd_terminal = 0;
    upd_state = 0; upd_action = 0; upd_next_state = 0; upd_reward = 0;
    upd_alpha = 0; upd_gamma = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", upd_ready, 0);
    chk("rst_done", init_done, 0);
    chk("rst_valid", res_valid, 0);
    @(negedge clk); rst = 0;
    wait_init("a");

    do_upd(2, 1, 3, 16'h0100, 0, 9'h080, 9'h080, 0, q, mq, best, sat, lat);
    chk("t1_q", q, 16'h0080); chk("t1_mq", mq, 0); chk("t1_best", best, 0);
    chk("t1_sat", sat, 0); chk("t1_lat", lat, 5);

    do_upd(1, 0, 2, 16'h0000, 0, 9'h080, 9'h080, 10, q, mq, best, sat, lat);
    chk("t2_q", q, 16'h0020); chk("t2_mq", mq, 16'h0080); chk("t2_best", best, 1);

    do_upd(2, 1, 2, 16'h0100, 1, 9'h080, 9'h080, 0, q, mq, best, sat, lat);
    chk("t3_q", q, 16'h00C0); chk("t3_mq", mq, 0); chk("t3_best", best, 0);

    do_upd(5, 0, 0, 16'h7FFF, 1, 9'h100, 9'h000, 0, q, mq, best, sat, lat);
    chk("t4_q", q, 16'h7FFF); chk("t4_sat", sat, 0);
    do_upd(5, 0, 5, 16'h7FFF, 0, 9'h100, 9'h100, 0, q, mq, best, sat, lat);
    chk("t5_q", q, 16'h7FFF); chk("t5_sat", sat, 1); chk("t5_mq", mq, 16'h7FFF);

    do_upd(7, 3, 8, 16'hFFFF, 0, 9'h080, 9'h000, 0, q, mq, best, sat, lat);
    chk("t6_q", q, 16'hFFFF); chk("t6_sat", sat, 0);

    // Abort an update to (9,2) two cycles into SCAN.
    @(negedge clk);
    upd_state = 9; upd_action = 2; upd_next_state = 4; upd_reward = 16'h0100;
    upd_terminal = 0; upd_alpha = 9'h100; upd_gamma = 0; upd_valid = 1;
    @(posedge clk); #1 upd_valid = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1;
    #1;
    chk("abort_valid", res_valid, 0); chk("abort_q", res_q, 0);
    chk("abort_mq", res_max_q, 0); chk("abort_sat", res_sat, 0);
    chk("abort_best", res_best_action, 0);
    chk("abort_rdy", upd_ready, 0); chk("abort_done", init_done, 0);
    @(negedge clk); rst = 0;
    wait_init("b");
    // alpha=0 leaves the entry unchanged, so res_q reads it back.
    do_upd(9, 2, 9, 16'h0100, 0, 9'h000, 9'h100, 0, q, mq, best, sat, lat);
    chk("abort_entry", q, 0); chk("abort_entry_mq", mq, 0);
    // Previously written (2,1)=0xC0 must be cleared by the second INIT.
    do_upd(0, 0, 2, 16'h0000, 0, 9'h000, 9'h100, 0, q, mq, best, sat, lat);
    chk("reinit_mq", mq, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
